alu_exec_seq: RTL and testbench
===============================

// Module: alu_exec_seq
// PURPOSE
//  Execute sequencer directly upstream of the 16-bit SAP ALU: accepts a command (opcode + operand)
//  from the control unit, drives the ALU inputs from its accumulator and operand registers, and
//  writes the ALU result and flags back into the accumulator and flag register.
//  Returns a response (result, flags, error) to the control unit via a valid/ready handshake.
// PARAMETERS
//  WIDTH   16  datapath width; accumulator, operand and ALU operand width
//  OP_W    4   opcode width; matches the ALU op field
// PORTS
//  clk          in   1       system clock, rising edge
//  rst_n        in   1       synchronous active-low reset
//  cmd_valid    in   1       command present
//  cmd_ready    out  1       sequencer can accept a command
//  cmd_op       in   OP_W    opcode: 0-7 ALU ops (ADD,SUB,INC,DEC,AND,OR,XOR,NOT), 8 LDA, 9 CLR, 10-15 illegal
//  cmd_operand  in   WIDTH   B operand (LDA: load value)
//  alu_a        out  WIDTH   to ALU a = accumulator register
//  alu_b        out  WIDTH   to ALU b = latched operand register
//  alu_op       out  OP_W    to ALU op = latched opcode register
//  alu_result   in   WIDTH   from ALU result (combinational)
//  alu_flag     in   2       from ALU: [0] zero, [1] overflow/bit16
//  rsp_valid    out  1       response present
//  rsp_ready    in   1       consumer accepts response
//  rsp_data     out  WIDTH   accumulator value after the command
//  rsp_flags    out  2       flag register after the command
//  rsp_err      out  1       1 = illegal opcode; no state changed
//  acc_out      out  WIDTH   accumulator, continuously visible
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge): state=IDLE; acc, operand reg, op reg, flags, rsp_err = 0;
//    cmd_ready=1 and rsp_valid=0 from the first cycle after reset. Reset overrides everything and
//    aborts any in-flight command with no writeback and no response.
//  - alu_a/alu_b/alu_op are register outputs only; never combinational from cmd_*.
//  - FSM states: IDLE, EXEC, RESP.
//    IDLE: cmd_ready=1. On cmd_valid=1 at an edge, latch cmd_op into op reg and cmd_operand into
//          operand reg, then go to EXEC.
//    EXEC: cmd_ready=0. ALU inputs stable for the whole cycle. At the edge, apply writeback, then go to RESP:
//          op 0-7: acc<=alu_result, flags<=alu_flag, rsp_err<=0
//          op 8:   acc<=operand, flags<={1'b0, operand==0}, rsp_err<=0
//          op 9:   acc<=0, flags<=2'b01, rsp_err<=0
//          op 10-15: acc and flags unchanged, rsp_err<=1
//    RESP: rsp_valid=1, cmd_ready=0. rsp_data=acc, rsp_flags=flags. All stable while rsp_ready=0.
//          On rsp_ready=1 at an edge, go to IDLE.
//  - Latency: cmd accepted at edge N; acc/flags updated at edge N+1; rsp_valid high during cycle N+1.
//    Earliest response handshake is at edge N+2; earliest next command is accepted at edge N+3.
//  - cmd_valid is ignored outside IDLE; a command held across RESP is accepted only after the return to IDLE.
//  - Arithmetic is modulo 2^WIDTH. Overflow semantics are exactly the ALU's flag[1]; no reinterpretation.
//  - rsp_err is cleared by the next legal command, not by the handshake.
// TESTING
//  1 Reset: assert rst_n=0 during EXEC of an ADD -> acc=0, flags=0, rsp_valid=0, cmd_ready=1, no response.
//  2 LDA 0x0005, then ADD 0x0003 -> rsp_data=0x0008, rsp_flags=2'b00; rsp_valid one cycle after acceptance.
//  3 From acc=0x0008: SUB 0x0008 -> rsp_data=0x0000, rsp_flags=2'b01;
//    then DEC -> rsp_data=0xFFFF, rsp_flags=ALU flag.
//  4 LDA 0x8000, then ADD 0x8000 -> rsp_data=0x0000, rsp_flags=2'b11; then CLR -> rsp_data=0, flags=2'b01.
//  5 Illegal op 4'hC with acc=0x1234 -> rsp_err=1, rsp_data=0x1234, flags unchanged;
//    next LDA 0x0001 -> rsp_err=0.
//  6 Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid/data/flags held stable, cmd_ready=0,
//    and a cmd_valid pulse in that window is ignored.

Source files
------------

// File: rtl/alu_exec_seq.sv
// Execute sequencer in front of the 16-bit SAP ALU. It latches a command,
// drives the ALU from its registers, writes the result back into the
// accumulator, and returns a valid/ready response.
module alu_exec_seq #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned OP_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [OP_W-1:0]  cmd_op,
    input  logic [WIDTH-1:0] cmd_operand,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OP_W-1:0]  alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [1:0]       alu_flag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [1:0]       rsp_flags,
    output logic             rsp_err,
    output logic [WIDTH-1:0] acc_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Opcodes below LDA are handed to the ALU; those above CLR are illegal.
    localparam logic [OP_W-1:0] OP_LDA = OP_W'(8);
    localparam logic [OP_W-1:0] OP_CLR = OP_W'(9);

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] operand_r;
    logic [OP_W-1:0]  op_r;
    logic [1:0]       flags;

    // The ALU only ever sees registered values, never the cmd_* inputs directly.
    assign alu_a     = acc;
    assign alu_b     = operand_r;
    assign alu_op    = op_r;
    assign rsp_data  = acc;
    assign rsp_flags = flags;
    assign acc_out   = acc;

    // Sequencer: accept, execute and write back, then hold the response until it is taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            operand_r <= '0;
            op_r      <= '0;
            flags     <= 2'b00;
            rsp_err   <= 1'b0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_r      <= cmd_op;
                        operand_r <= cmd_operand;
                        cmd_ready <= 1'b0;
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    if (op_r < OP_LDA) begin
                        acc     <= alu_result;
                        flags   <= alu_flag;
                        rsp_err <= 1'b0;
                    end else if (op_r == OP_LDA) begin
                        acc     <= operand_r;
                        flags   <= {1'b0, operand_r == '0};
                        rsp_err <= 1'b0;
                    end else if (op_r == OP_CLR) begin
                        acc     <= '0;
                        flags   <= 2'b01;
                        rsp_err <= 1'b0;
                    end else begin
                        rsp_err <= 1'b1;
                    end
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_seq.sv
// Directed bench for alu_exec_seq with a behavioural 16-bit ALU attached.
module tb_alu_exec_seq;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned OP_W  = 4;

    logic             clk;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [OP_W-1:0]  cmd_op;
    logic [WIDTH-1:0] cmd_operand;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [OP_W-1:0]  alu_op;
    logic [WIDTH-1:0] alu_result;
    logic [1:0]       alu_flag;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic [1:0]       rsp_flags;
    logic             rsp_err;
    logic [WIDTH-1:0] acc_out;

    int pass_cnt = 0;
    int total_cnt = 0;

    alu_exec_seq #(.WIDTH(WIDTH), .OP_W(OP_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_operand (cmd_operand),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .alu_flag    (alu_flag),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_flags   (rsp_flags),
        .rsp_err     (rsp_err),
        .acc_out     (acc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: 17-bit result, flag[1] = bit 16, flag[0] = zero.
    logic [16:0] alu_r;
    always_comb begin
        alu_r = 17'd0;
        case (alu_op)
            4'd0: alu_r = {1'b0, alu_a} + {1'b0, alu_b};
            4'd1: alu_r = {1'b0, alu_a} - {1'b0, alu_b};
            4'd2: alu_r = {1'b0, alu_a} + 17'd1;
            4'd3: alu_r = {1'b0, alu_a} - 17'd1;
            4'd4: alu_r = {1'b0, alu_a & alu_b};
            4'd5: alu_r = {1'b0, alu_a | alu_b};
            4'd6: alu_r = {1'b0, alu_a ^ alu_b};
            4'd7: alu_r = {1'b0, ~alu_a};
            default: alu_r = 17'd0;
        endcase
        alu_result = alu_r[15:0];
        alu_flag   = {alu_r[16], alu_r[15:0] == 16'd0};
    end

    typedef struct {
        logic [3:0]  op;
        logic [15:0] operand;
        logic [15:0] exp_data;
        logic [1:0]  exp_flags;
        logic        exp_err;
    } vec_t;

    vec_t vecs [0:17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one command, check EXEC latency, response contents and return to IDLE.
    task automatic do_cmd(input logic [3:0] op, input logic [15:0] operand,
                          input logic [15:0] exp_data, input logic [1:0] exp_flags,
                          input logic exp_err, input int idx);
        int waited = 0;
        while (!cmd_ready && waited < 20) begin
            tick();
            waited++;
        end
        check($sformatf("v%0d_ready_timeout", idx), 32'(cmd_ready), 32'd1);
        cmd_op      = op;
        cmd_operand = operand;
        cmd_valid   = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check($sformatf("v%0d_exec_valid", idx), 32'(rsp_valid), 32'd0);
        check($sformatf("v%0d_exec_ready", idx), 32'(cmd_ready), 32'd0);
        tick();
        check($sformatf("v%0d_rsp_valid", idx), 32'(rsp_valid), 32'd1);
        check($sformatf("v%0d_rsp_data", idx), 32'(rsp_data), 32'(exp_data));
        check($sformatf("v%0d_rsp_flags", idx), 32'(rsp_flags), 32'(exp_flags));
        check($sformatf("v%0d_rsp_err", idx), 32'(rsp_err), 32'(exp_err));
        check($sformatf("v%0d_acc_out", idx), 32'(acc_out), 32'(exp_data));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check($sformatf("v%0d_post_valid", idx), 32'(rsp_valid), 32'd0);
        check($sformatf("v%0d_post_ready", idx), 32'(cmd_ready), 32'd1);
        check($sformatf("v%0d_post_err", idx), 32'(rsp_err), 32'(exp_err));
    endtask

    initial begin
        //        op     operand   data      flags  err
        vecs[0]  = '{4'h8, 16'h0005, 16'h0005, 2'b00, 1'b0}; // LDA 5
        vecs[1]  = '{4'h0, 16'h0003, 16'h0008, 2'b00, 1'b0}; // ADD 3
        vecs[2]  = '{4'h1, 16'h0008, 16'h0000, 2'b01, 1'b0}; // SUB 8
        vecs[3]  = '{4'h3, 16'h0000, 16'hFFFF, 2'b10, 1'b0}; // DEC borrow
        vecs[4]  = '{4'h8, 16'h8000, 16'h8000, 2'b00, 1'b0}; // LDA 0x8000
        vecs[5]  = '{4'h0, 16'h8000, 16'h0000, 2'b11, 1'b0}; // ADD wraps
        vecs[6]  = '{4'h9, 16'h1111, 16'h0000, 2'b01, 1'b0}; // CLR
        vecs[7]  = '{4'h8, 16'h1234, 16'h1234, 2'b00, 1'b0}; // LDA 0x1234
        vecs[8]  = '{4'hC, 16'h5555, 16'h1234, 2'b00, 1'b1}; // illegal
        vecs[9]  = '{4'h8, 16'h0001, 16'h0001, 2'b00, 1'b0}; // LDA clears err
        vecs[10] = '{4'h6, 16'hFFFF, 16'hFFFE, 2'b00, 1'b0}; // XOR
        vecs[11] = '{4'h7, 16'h0000, 16'h0001, 2'b00, 1'b0}; // NOT
        vecs[12] = '{4'h4, 16'h0000, 16'h0000, 2'b01, 1'b0}; // AND 0
        vecs[13] = '{4'h5, 16'h00F0, 16'h00F0, 2'b00, 1'b0}; // OR
        vecs[14] = '{4'h2, 16'h0000, 16'h00F1, 2'b00, 1'b0}; // INC
        vecs[15] = '{4'h8, 16'h0000, 16'h0000, 2'b01, 1'b0}; // LDA 0 sets zero
        vecs[16] = '{4'hF, 16'hAAAA, 16'h0000, 2'b01, 1'b1}; // illegal keeps flags
        vecs[17] = '{4'h8, 16'hFFFF, 16'hFFFF, 2'b00, 1'b0}; // LDA 0xFFFF

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_operand = '0; rsp_ready = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_acc", 32'(acc_out), 32'd0);
        check("rst_flags", 32'(rsp_flags), 32'd0);
        check("rst_err", 32'(rsp_err), 32'd0);
        check("rst_alu_b", 32'(alu_b), 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'd0);

        for (int i = 0; i < 18; i++)
            do_cmd(vecs[i].op, vecs[i].operand, vecs[i].exp_data,
                   vecs[i].exp_flags, vecs[i].exp_err, i);

        // INC wraps from 0xFFFF
        do_cmd(4'h2, 16'h0000, 16'h0000, 2'b11, 1'b0, 100);
        do_cmd(4'h8, 16'h0077, 16'h0077, 2'b00, 1'b0, 101);

        // Backpressure: response held for 5 cycles, stray command ignored
        cmd_op = 4'h8; cmd_operand = 16'h00AA; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                cmd_op = 4'h8; cmd_operand = 16'h5555; cmd_valid = 1'b1;
            end else begin
                cmd_valid = 1'b0;
            end
            check($sformatf("bp%0d_valid", c), 32'(rsp_valid), 32'd1);
            check($sformatf("bp%0d_data", c), 32'(rsp_data), 32'h00AA);
            check($sformatf("bp%0d_flags", c), 32'(rsp_flags), 32'd0);
            check($sformatf("bp%0d_cmd_ready", c), 32'(cmd_ready), 32'd0);
            tick();
        end
        cmd_valid = 1'b0;
        check("bp_alu_b_kept", 32'(alu_b), 32'h00AA);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("bp_done_valid", 32'(rsp_valid), 32'd0);
        check("bp_done_ready", 32'(cmd_ready), 32'd1);
        check("bp_acc", 32'(acc_out), 32'h00AA);

        // Reset during EXEC of an ADD aborts it with no writeback and no response
        cmd_op = 4'h0; cmd_operand = 16'h0003; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("abort_in_exec", 32'(cmd_ready), 32'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_acc", 32'(acc_out), 32'd0);
        check("abort_flags", 32'(rsp_flags), 32'd0);
        check("abort_valid", 32'(rsp_valid), 32'd0);
        check("abort_ready", 32'(cmd_ready), 32'd1);
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("abort_quiet%0d", c), 32'(rsp_valid), 32'd0);
        end
        do_cmd(4'h0, 16'h0009, 16'h0009, 2'b00, 1'b0, 102);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
